lts_time_avg: RTL and testbench
===============================

// Module: lts_time_avg
// PURPOSE
//  Consumes the two back-to-back 64-sample LTS symbols emitted by the long-sync stage (tlast after each symbol).
//  Stores LTS1, then averages it sample-by-sample with LTS2 in the time domain.
//  Emits one 64-sample averaged symbol (3 dB noise reduction) to the downstream FFT.
//  Sits between long-sync and the FFT in the CSI extractor receive chain.
// PARAMETERS
//  N_SYM    64   samples per LTS symbol (power of 2)
//  DW       16   I/Q sample width, signed two's complement
// PORTS
//  clk_in            in   1    single system clock
//  rst_in            in   1    asynchronous, active-high reset
//  lts_axis_tvalid   in   1    input beat valid
//  lts_axis_tlast    in   1    input end-of-symbol marker
//  lts_i_axis_tdata  in   DW   input I sample
//  lts_q_axis_tdata  in   DW   input Q sample
//  lts_axis_tready   out  1    input ready
//  avg_axis_tvalid   out  1    output beat valid
//  avg_axis_tlast    out  1    high on 64th averaged sample
//  avg_i_axis_tdata  out  DW   averaged I
//  avg_q_axis_tdata  out  DW   averaged Q
//  avg_axis_tready   in   1    downstream ready
//  frame_err         out  1    one-cycle pulse on tlast/count mismatch
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - state=CAPTURE, idx=0.
//   - All outputs 0 except lts_axis_tready=1.
//   - Buffer contents are don't-care.
//  Beat acceptance: beat accepted when lts_axis_tvalid && lts_axis_tready; idx counts accepted beats 0..N_SYM-1.
//  CAPTURE (LTS1)
//   - tready=1 unconditionally.
//   - Accepted beat is written to buf[idx] (N_SYM x 2*DW register array).
//   - At idx==N_SYM-1 with tlast: idx<=0, go to AVERAGE.
//  AVERAGE (LTS2)
//   - tready = !avg_axis_tvalid || avg_axis_tready (single output register, no bubble).
//   - Accepted beat: out_i <= (buf_i[idx] + in_i + 1) >>> 1, computed at DW+1 bits; same for Q.
//   - Result always fits DW; no saturation needed (range -32768..32767).
//   - avg_axis_tvalid is set on the next edge, so latency is 1 cycle.
//   - avg_axis_tlast = (idx==N_SYM-1).
//   - At idx==N_SYM-1: idx<=0, go to CAPTURE.
//   - Next LTS1 may be accepted while the last averaged beat is still stalled.
//  Output register
//   - Holds data, tvalid and tlast stable while tvalid && !tready.
//   - tvalid clears on a handshake unless a new beat is loaded in the same cycle.
//  Framing errors
//   - tlast at idx<N_SYM-1, or no tlast at idx==N_SYM-1, pulses frame_err one cycle after acceptance.
//   - In CAPTURE: the beat is stored, idx<=0, stay in CAPTURE (discard partial LTS1).
//   - In AVERAGE, early tlast: the beat is averaged and emitted with avg_axis_tlast=1, idx<=0, go to CAPTURE.
//   - In AVERAGE, missing tlast at idx==N_SYM-1: the frame still closes normally with avg_axis_tlast=1.
//  Mid-operation reset: any partial frame is dropped, no output beat survives, next accepted beat is LTS1 idx 0.
// TESTING
//  1. LTS1 all I=100,Q=-100; LTS2 all I=300,Q=-301, tready=1 -> 64 outputs I=200,Q=-200, tlast on #64 only, 1-cycle latency.
//  2. Extremes: 32767+32767 -> 32767; -32768+-32768 -> -32768; 1+0 -> 1; -1+0 -> 0; no overflow.
//  3. avg_axis_tready random 50% during LTS2 -> lts_axis_tready back-pressures; output sequence is exact and data holds stable while stalled.
//  4. Early tlast at LTS1 beat 40 -> frame_err pulse; next 128 valid beats produce one correct 64-beat frame.
//  5. rst_in asserted at LTS2 beat 20 -> outputs 0 immediately; new clean frame afterwards averages correctly.
//  6. Two frames back-to-back with last output stalled 5 cycles -> LTS1 of frame 2 accepted meanwhile; both frames correct.

Source files
------------

// File: rtl/lts_time_avg.sv
// Time-domain LTS averager: captures LTS1 into a register array, then emits
// round-half-up averages of LTS1 and LTS2 through a single skid-free output register.
module lts_time_avg #(
  parameter int N_SYM = 64,
  parameter int DW    = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          lts_axis_tvalid,
  input  logic          lts_axis_tlast,
  input  logic [DW-1:0] lts_i_axis_tdata,
  input  logic [DW-1:0] lts_q_axis_tdata,
  output logic          lts_axis_tready,
  output logic          avg_axis_tvalid,
  output logic          avg_axis_tlast,
  output logic [DW-1:0] avg_i_axis_tdata,
  output logic [DW-1:0] avg_q_axis_tdata,
  input  logic          avg_axis_tready,
  output logic          frame_err
);

  localparam int IW = $clog2(N_SYM);
  localparam logic [0:0] CAPTURE = 1'b0;
  localparam logic [0:0] AVERAGE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic [DW-1:0] oi_q, oi_d;
  logic [DW-1:0] oq_q, oq_d;
  logic          err_q, err_d;

  logic [DW-1:0] lts1_i_q [N_SYM];
  logic [DW-1:0] lts1_q_q [N_SYM];

  logic          accept, last_idx, close, load;
  logic [DW:0]   sum_i, sum_q;

  always_comb begin
    lts_axis_tready = (state_q == CAPTURE) ? 1'b1 : (!vld_q || avg_axis_tready);
    accept   = lts_axis_tvalid && lts_axis_tready;
    last_idx = (idx_q == IW'(N_SYM - 1));
    close    = lts_axis_tlast || last_idx;
    load     = accept && (state_q == AVERAGE);
    // One extra bit keeps the +1 rounding term from overflowing before the halving.
    sum_i = {lts1_i_q[idx_q][DW-1], lts1_i_q[idx_q]}
          + {lts_i_axis_tdata[DW-1], lts_i_axis_tdata} + (DW+1)'(1);
    sum_q = {lts1_q_q[idx_q][DW-1], lts1_q_q[idx_q]}
          + {lts_q_axis_tdata[DW-1], lts_q_axis_tdata} + (DW+1)'(1);

    state_d = state_q;
    idx_d   = idx_q;
    err_d   = accept && (lts_axis_tlast != last_idx);
    if (accept) begin
      if (close) begin
        idx_d = '0;
        if (state_q == AVERAGE)
          state_d = CAPTURE;
        else if (lts_axis_tlast && last_idx)
          state_d = AVERAGE;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    vld_d  = load ? 1'b1 : (avg_axis_tready ? 1'b0 : vld_q);
    last_d = load ? close : last_q;
    oi_d   = load ? sum_i[DW:1] : oi_q;
    oq_d   = load ? sum_q[DW:1] : oq_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= CAPTURE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      oi_q    <= '0;
      oq_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      oi_q    <= oi_d;
      oq_q    <= oq_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (accept && (state_q == CAPTURE)) begin
      lts1_i_q[idx_q] <= lts_i_axis_tdata;
      lts1_q_q[idx_q] <= lts_q_axis_tdata;
    end
  end

  assign avg_axis_tvalid  = vld_q;
  assign avg_axis_tlast   = last_q;
  assign avg_i_axis_tdata = oi_q;
  assign avg_q_axis_tdata = oq_q;
  assign frame_err        = err_q;

endmodule

// File: tb/tb_lts_time_avg.sv
// Scoreboard bench for lts_time_avg: driver pushes expected averages on LTS2 acceptance,
// a negedge monitor checks output beats, latency, stall stability and frame_err.
module tb_lts_time_avg;
  localparam int N = 64;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic lts_axis_tvalid = 1'b0, lts_axis_tlast = 1'b0;
  logic signed [15:0] lts_i = '0, lts_q = '0;
  logic lts_axis_tready;
  logic avg_axis_tvalid, avg_axis_tlast, frame_err;
  logic signed [15:0] avg_i, avg_q;
  logic avg_axis_tready = 1'b1;

  lts_time_avg #(.N_SYM(N), .DW(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .lts_axis_tvalid(lts_axis_tvalid), .lts_axis_tlast(lts_axis_tlast),
    .lts_i_axis_tdata(lts_i), .lts_q_axis_tdata(lts_q),
    .lts_axis_tready(lts_axis_tready),
    .avg_axis_tvalid(avg_axis_tvalid), .avg_axis_tlast(avg_axis_tlast),
    .avg_i_axis_tdata(avg_i), .avg_q_axis_tdata(avg_q),
    .avg_axis_tready(avg_axis_tready), .frame_err(frame_err));

  always #5 clk_in = ~clk_in;

  typedef struct { int i; int q; bit last; int cyc; } exp_t;
  exp_t sbq[$];
  bit   err_at[int];
  int   cyc = 0;
  int   vecs = 0, miss = 0;
  int   src_i[N], src_q[N], ref_i[N], ref_q[N];
  bit   rdy_rand = 0, rdy_hold = 0, gaps = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    #2;
    avg_axis_tready = rdy_hold ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Round-half-up mean, computed as floor((a+b+1)/2).
  function automatic int avg2(input int a, input int b);
    int s;
    s = a + b + 1;
    return (s >= 0) ? s / 2 : -((-s + 1) / 2);
  endfunction

  bit prev_stall = 0, prev_last = 0;
  int prev_i = 0, prev_q = 0;
  always @(negedge clk_in) begin
    bit e_err;
    exp_t e;
    if (rst_in) prev_stall = 0;
    else begin
      e_err = err_at.exists(cyc) ? err_at[cyc] : 1'b0;
      vecs++;
      if (frame_err !== e_err) begin
        miss++; $display("FAIL frame_err cyc=%0d got=%b exp=%b", cyc, frame_err, e_err);
      end
      if (prev_stall) begin
        vecs++;
        if (!(avg_axis_tvalid && int'(avg_i) == prev_i && int'(avg_q) == prev_q && avg_axis_tlast == prev_last)) begin
          miss++;
          $display("FAIL stall_hold cyc=%0d got v=%b i=%0d q=%0d l=%b exp v=1 i=%0d q=%0d l=%b",
                   cyc, avg_axis_tvalid, avg_i, avg_q, avg_axis_tlast, prev_i, prev_q, prev_last);
        end
      end else if (avg_axis_tvalid) begin
        vecs++;
        if (sbq.size() == 0) begin
          miss++; $display("FAIL unexpected_out cyc=%0d got i=%0d q=%0d exp none", cyc, avg_i, avg_q);
        end else begin
          e = sbq[0];
          if (int'(avg_i) != e.i || int'(avg_q) != e.q || avg_axis_tlast != e.last || cyc != e.cyc) begin
            miss++;
            $display("FAIL out_beat got i=%0d q=%0d l=%b cyc=%0d exp i=%0d q=%0d l=%b cyc=%0d",
                     avg_i, avg_q, avg_axis_tlast, cyc, e.i, e.q, e.last, e.cyc);
          end
        end
      end
      if (avg_axis_tvalid && avg_axis_tready && sbq.size() > 0) void'(sbq.pop_front());
      prev_stall = avg_axis_tvalid && !avg_axis_tready;
      prev_i = int'(avg_i); prev_q = int'(avg_q); prev_last = avg_axis_tlast;
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    lts_axis_tvalid = 1'b0;
    #1;
    vecs++;
    if (avg_axis_tvalid || avg_axis_tlast || avg_i != 0 || avg_q != 0 || frame_err || !lts_axis_tready) begin
      miss++;
      $display("FAIL reset_outs got v=%b l=%b i=%0d q=%0d err=%b rdy=%b exp 0 0 0 0 0 1",
               avg_axis_tvalid, avg_axis_tlast, avg_i, avg_q, frame_err, lts_axis_tready);
    end
    sbq.delete();
    err_at.delete();
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask

  // Sends one symbol from src_*; tlast on beat tl_at; reset instead of beat abort_at.
  task automatic send_sym(input bit is_avg, input int len, input int tl_at, input int abort_at);
    for (int k = 0; k < len; k++) begin
      int waited;
      exp_t e;
      if (k == abort_at) begin do_reset(); return; end
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk_in); #1; end
      lts_axis_tvalid = 1'b1;
      lts_axis_tlast  = (k == tl_at);
      lts_i = 16'(src_i[k]);
      lts_q = 16'(src_q[k]);
      waited = 0;
      forever begin
        @(negedge clk_in);
        if (lts_axis_tready) break;
        waited++;
        if (waited > 200) begin
          vecs++; miss++;
          $display("FAIL accept_timeout beat=%0d got tready=0 exp tready=1", k);
          lts_axis_tvalid = 1'b0;
          return;
        end
      end
      err_at[cyc + 1] = ((k == tl_at) != (k == N - 1));
      if (is_avg) begin
        e.i = avg2(ref_i[k], src_i[k]);
        e.q = avg2(ref_q[k], src_q[k]);
        e.last = (k == tl_at) || (k == N - 1);
        e.cyc = cyc + 1;
        sbq.push_back(e);
      end else begin
        ref_i[k] = src_i[k];
        ref_q[k] = src_q[k];
      end
      @(posedge clk_in); #1;
      lts_axis_tvalid = 1'b0;
      lts_axis_tlast  = 1'b0;
    end
  endtask

  task automatic fill_const(input int vi, input int vq);
    for (int k = 0; k < N; k++) begin src_i[k] = vi; src_q[k] = vq; end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      src_i[k] = int'($urandom_range(0, 65535)) - 32768;
      src_q[k] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic clean_frame();
    fill_rand(); send_sym(0, N, N - 1, -1);
    fill_rand(); send_sym(1, N, N - 1, -1);
  endtask

  initial begin
    do_reset();

    // 1: constant symbols, full-rate downstream
    fill_const(100, -100);  send_sym(0, N, N - 1, -1);
    fill_const(300, -301);  send_sym(1, N, N - 1, -1);

    // 2: numeric extremes
    fill_rand();
    src_i[0] = 32767;  src_q[0] = -32768;
    src_i[1] = -32768; src_q[1] = 32767;
    src_i[2] = 1;      src_q[2] = -1;
    src_i[3] = -1;     src_q[3] = 1;
    send_sym(0, N, N - 1, -1);
    fill_rand();
    src_i[0] = 32767;  src_q[0] = -32768;
    src_i[1] = -32768; src_q[1] = 32767;
    src_i[2] = 0;      src_q[2] = 0;
    src_i[3] = 0;      src_q[3] = 0;
    send_sym(1, N, N - 1, -1);

    // 3: random downstream back-pressure with random input gaps
    rdy_rand = 1; gaps = 1;
    repeat (3) clean_frame();
    rdy_rand = 0; gaps = 0;

    // 4: early tlast in LTS1, then one clean frame
    fill_rand(); send_sym(0, 41, 40, -1);
    clean_frame();

    // early tlast and missing tlast during LTS2
    fill_rand(); send_sym(0, N, N - 1, -1);
    fill_rand(); send_sym(1, 11, 10, -1);
    fill_rand(); send_sym(0, N, N - 1, -1);
    fill_rand(); send_sym(1, N, -1, -1);
    clean_frame();

    // 5: reset at LTS2 beat 20, then clean frame
    fill_rand(); send_sym(0, N, N - 1, -1);
    fill_rand(); send_sym(1, N, N - 1, 20);
    clean_frame();

    // 6: last output of frame 1 stalled while LTS1 of frame 2 flows in
    fill_rand(); send_sym(0, N, N - 1, -1);
    fill_rand(); send_sym(1, N, N - 1, -1);
    rdy_hold = 1;
    fork begin repeat (5) @(posedge clk_in); rdy_hold = 0; end join_none
    @(negedge clk_in);
    vecs++;
    if (!(avg_axis_tvalid && avg_axis_tlast && lts_axis_tready)) begin
      miss++;
      $display("FAIL stall_accept got v=%b l=%b rdy=%b exp 1 1 1", avg_axis_tvalid, avg_axis_tlast, lts_axis_tready);
    end
    @(posedge clk_in); #1;
    clean_frame();

    begin
      int w;
      w = 0;
      while (sbq.size() != 0 && w < 1000) begin @(posedge clk_in); w++; end
      repeat (3) @(posedge clk_in);
      vecs++;
      if (sbq.size() != 0) begin
        miss++; $display("FAIL drain got %0d pending exp 0", sbq.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
